// File: rtl/cpu_pkg.sv
// Shared CPU typedefs, including the state encoding of the iterative divider.
package cpu_pkg;

   typedef logic [31:0] t_word;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_DIV,
      S_FIX,
      S_DONE
   } t_div_state;

endpackage

// File: rtl/div_step.sv
// One combinational restoring shift-subtract step of the divider.
module div_step #(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   // rem_in < divisor always holds, so the top bit of the WIDTH+1-bit difference is the borrow.
   always_comb begin
      shifted = {rem_in, bit_in};
      diff    = shifted - {1'b0, divisor};
      q_bit   = ~diff[WIDTH];
      rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands (default build is unsigned).
module div_unit
   import cpu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   t_div_state state_q, state_d;

   logic [WIDTH-1:0] dvd_q, dvs_q;
   logic [WIDTH-1:0] rem_q, shf_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic             div_zero_q;

   logic [WIDTH-1:0] dvd_mag, dvs_mag;
   logic [WIDTH-1:0] q_fix, r_fix;
   logic [WIDTH-1:0] step_rem;
   logic             step_q;

   div_step #(
      .WIDTH(WIDTH)
   ) u_div_step (
      .rem_in (rem_q),
      .bit_in (shf_q[WIDTH-1]),
      .divisor(dvs_mag),
      .rem_out(step_rem),
      .q_bit  (step_q)
   );

`ifdef DIV_SIGNED_EN
   logic dvd_neg, dvs_neg;

   // Quotient truncates toward zero; remainder follows the dividend's sign.
   always_comb begin
      dvd_neg = dvd_q[WIDTH-1];
      dvs_neg = dvs_q[WIDTH-1];
      dvd_mag = dvd_neg ? -dvd_q : dvd_q;
      dvs_mag = dvs_neg ? -dvs_q : dvs_q;
      q_fix   = (dvd_neg ^ dvs_neg) ? -shf_q : shf_q;
      r_fix   = dvd_neg ? -rem_q : rem_q;
   end
`else
   always_comb begin
      dvd_mag = dvd_q;
      dvs_mag = dvs_q;
      q_fix   = shf_q;
      r_fix   = rem_q;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_CHECK;
         S_CHECK: state_d = (dvs_q == '0) ? S_DONE : S_DIV;
         S_DIV:   if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
         S_FIX:   state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // Quotient bits enter shf_q at the LSB as dividend bits leave at the MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dvd_q       <= '0;
         dvs_q       <= '0;
         rem_q       <= '0;
         shf_q       <= '0;
         cnt_q       <= '0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  dvd_q <= dividend;
                  dvs_q <= divisor;
               end
            end
            S_CHECK: begin
               if (dvs_q == '0) begin
                  quotient_q  <= '1;
                  remainder_q <= dvd_q;
                  div_zero_q  <= 1'b1;
               end else begin
                  rem_q <= '0;
                  shf_q <= dvd_mag;
                  cnt_q <= '0;
               end
            end
            S_DIV: begin
               rem_q <= step_rem;
               shf_q <= {shf_q[WIDTH-2:0], step_q};
               cnt_q <= cnt_q + 1'b1;
            end
            S_FIX: begin
               quotient_q  <= q_fix;
               remainder_q <= r_fix;
               div_zero_q  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: a 16-bit and a 32-bit instance share clock and reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start16, start32;
   logic [15:0] dividend16, divisor16, q16, r16;
   logic [31:0] dividend32, divisor32, q32, r32;
   logic        busy16, done16, dz16, busy32, done32, dz32;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] a, b, q, r;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[6];

   always #5 clk = ~clk;

   div_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .dividend(dividend16), .divisor(divisor16),
      .busy(busy16), .done(done16), .quotient(q16), .remainder(r16), .div_zero(dz16)
   );

   div_unit #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start32), .dividend(dividend32), .divisor(divisor32),
      .busy(busy32), .done(done32), .quotient(q32), .remainder(r32), .div_zero(dz32)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Start cycle is cycle 0; lat is the cycle in which done is seen.
   // A stray start mid-operation and one in the done cycle must both be ignored.
   task automatic run_div(input bit w32, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] q, output logic [31:0] r,
                          output logic dz);
      @(negedge clk);
      if (w32) begin
         dividend32 = a; divisor32 = b; start32 = 1'b1;
      end else begin
         dividend16 = a[15:0]; divisor16 = b[15:0]; start16 = 1'b1;
      end
      @(negedge clk);
      start16 = 1'b0; start32 = 1'b0;
      dividend16 = 16'hA5A5; divisor16 = 16'h0001;
      dividend32 = 32'hA5A5A5A5; divisor32 = 32'h1;
      lat = 1;
      while (((w32 ? done32 : done16) == 1'b0) && lat < 80) begin
         if (lat == 5) begin
            start16 = !w32; start32 = w32;
         end else begin
            start16 = 1'b0; start32 = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      q = w32 ? q32 : {16'h0, q16};
      r = w32 ? r32 : {16'h0, r16};
      dz = w32 ? dz32 : dz16;
      if (lat >= 80) begin
         check("done_timeout", 64'(lat), 64'd0);
      end else begin
         start16 = !w32; start32 = w32;
         @(negedge clk);
         start16 = 1'b0; start32 = 1'b0;
         check("done_one_pulse", w32 ? done32 : done16, 1'b0);
         check("no_accept_at_done", w32 ? busy32 : busy16, 1'b0);
      end
   endtask

   initial begin
      int          lat, n_done;
      logic [31:0] q, r;
      logic        dz;

      rst = 1'b1;
      start16 = 1'b0; start32 = 1'b0;
      dividend16 = '0; divisor16 = '0; dividend32 = '0; divisor32 = '0;
`ifdef DIV_SIGNED_EN
      vecs[0] = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 19};
      vecs[1] = '{16'd1234, 16'd0,    16'hFFFF, 16'd1234, 1'b1, 2};
      vecs[2] = '{16'hFFF9, 16'd2,    16'hFFFD, 16'hFFFF, 1'b0, 19};
      vecs[3] = '{16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 19};
      vecs[4] = '{16'd7,    16'hFFFE, 16'hFFFD, 16'd1,    1'b0, 19};
      vecs[5] = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 19};
`else
      vecs[0] = '{16'd100,   16'd7,   16'd14,    16'd2,    1'b0, 19};
      vecs[1] = '{16'd1234,  16'd0,   16'hFFFF,  16'd1234, 1'b1, 2};
      vecs[2] = '{16'd65535, 16'd255, 16'd257,   16'd0,    1'b0, 19};
      vecs[3] = '{16'd5,     16'd9,   16'd0,     16'd5,    1'b0, 19};
      vecs[4] = '{16'd0,     16'd5,   16'd0,     16'd0,    1'b0, 19};
      vecs[5] = '{16'd65535, 16'd1,   16'd65535, 16'd0,    1'b0, 19};
`endif

      repeat (2) @(negedge clk);
      check("rst_busy", busy16, 1'b0);
      check("rst_done", done16, 1'b0);
      check("rst_quot", q16, 16'h0);
      check("rst_rem", r16, 16'h0);
      check("rst_dz", dz16, 1'b0);
      check("rst_busy32", busy32, 1'b0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_div(1'b0, {16'h0, vecs[i].a}, {16'h0, vecs[i].b}, lat, q, r, dz);
         check($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
         check($sformatf("v%0d_quot", i), q, {16'h0, vecs[i].q});
         check($sformatf("v%0d_rem", i), r, {16'h0, vecs[i].r});
         check($sformatf("v%0d_dz", i), dz, vecs[i].dz);
      end

      run_div(1'b1, 32'hFFFFFFFF, 32'h1, lat, q, r, dz);
      check("w32_lat", 64'(lat), 64'd35);
      check("w32_quot", q, 32'hFFFFFFFF);
      check("w32_rem", r, 32'h0);
      check("w32_dz", dz, 1'b0);
      run_div(1'b1, 32'd1000000, 32'd7, lat, q, r, dz);
      check("w32b_quot", q, 32'd142857);
      check("w32b_rem", r, 32'd1);

      // Start held for 30 cycles: accepts at cycles 0 and 20 only.
      n_done = 0;
      for (int k = 0; k < 45; k++) begin
         @(negedge clk);
         if (done16) begin
            if (n_done == 0) begin
               check("hold0_cycle", 64'(k), 64'd19);
               check("hold0_quot", q16, 16'd333);
               check("hold0_rem", r16, 16'd1);
            end else if (n_done == 1) begin
               check("hold1_cycle", 64'(k), 64'd39);
               check("hold1_quot", q16, 16'd75);
               check("hold1_rem", r16, 16'd15);
            end
            n_done++;
         end
         start16 = (k < 30);
         dividend16 = 16'(1000 + 37 * k);
         divisor16 = 16'(3 + k);
      end
      start16 = 1'b0;
      check("hold_done_count", 64'(n_done), 64'd2);

      // Reset at cycle 8 of an operation.
      @(negedge clk);
      dividend16 = 16'd100; divisor16 = 16'd7; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", busy16, 1'b0);
      check("midrst_done", done16, 1'b0);
      check("midrst_quot", q16, 16'h0);
      check("midrst_rem", r16, 16'h0);
      check("midrst_dz", dz16, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      n_done = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (done16) n_done++;
      end
      check("midrst_no_done", 64'(n_done), 64'd0);
      run_div(1'b0, 32'd1000, 32'd9, lat, q, r, dz);
      check("post_rst_lat", 64'(lat), 64'd19);
      check("post_rst_quot", q, 32'd111);
      check("post_rst_rem", r, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; legal range 4..32.
REQ-002 Clock  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous and active-high.
REQ-004 Start  input  1  request pulse; sampled only in S_IDLE.
REQ-005 Dividend  input  WIDTH  numerator; captured on accepted Start.
REQ-006 Divisor  input  WIDTH  denominator; captured on accepted Start.
REQ-007 Busy  output  1  high in every state except S_IDLE.
REQ-008 Done  output  1  one-cycle pulse when results become valid.
REQ-009 Quotient  output  WIDTH  result; held stable from Done until the next accepted Start.
REQ-010 Remainder  output  WIDTH  result; same holding rule as Quotient.
REQ-011 DivZero  output  1  divide-by-zero flag; same holding rule as Quotient.

Function
REQ-012 The FSM SHALL have states S_IDLE, S_CHECK, S_DIV, S_FIX and S_DONE.
REQ-013 S_IDLE with Start=1 SHALL capture the operands and go to S_CHECK; Start=0 SHALL stay in S_IDLE.
REQ-014 S_CHECK SHALL go to S_DONE when Divisor==0; otherwise it SHALL load the remainder to 0, load the shift register from the dividend magnitude, clear the bit counter, and go to S_DIV.
REQ-015 S_DIV SHALL perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first, for exactly WIDTH cycles; the counter SHALL be $clog2(WIDTH)+1 bits wide and never wrap early.
REQ-016 The trial subtraction SHALL use a WIDTH+1-bit difference, so that no carry is lost at WIDTH=32.
REQ-017 S_FIX SHALL write Quotient and Remainder, apply sign correction when enabled (REQ-025), and go to S_DONE.
REQ-018 S_DONE SHALL assert Done for one cycle and return to S_IDLE.
REQ-019 Latency from the Start cycle to Done SHALL be WIDTH+3 cycles for a nonzero divisor and 2 cycles for a zero divisor.
REQ-020 On a zero divisor: Quotient SHALL be all ones, Remainder SHALL equal Dividend, and DivZero SHALL be 1.
REQ-021 In every other case DivZero SHALL be cleared to 0.
REQ-022 Start asserted while Busy=1 SHALL be ignored; it is not queued and has no effect on the operation in flight.
REQ-023 A Start in the same cycle as the Done-return to S_IDLE SHALL be ignored; it is accepted from the following cycle.

Reset
REQ-024 Rst=1 SHALL immediately force S_IDLE, Busy=0, Done=0, Quotient=0, Remainder=0 and DivZero=0; reset mid-operation SHALL abort that operation without producing a Done.

Configuration
REQ-025 With DIV_SIGNED_EN defined, operands SHALL be two's-complement:
- Division runs on magnitudes.
- The quotient is negated when the operand signs differ (truncation toward zero).
- The remainder takes the dividend's sign.
- The most-negative dividend divided by -1 SHALL give Quotient=most-negative and Remainder=0.
REQ-026 Without DIV_SIGNED_EN, operands SHALL be unsigned, S_FIX SHALL only write the results, and no sign logic SHALL be synthesised.

Structure
REQ-027 The state typedef t_div_state (enum logic [2:0]) SHALL live in cpu_pkg beside the existing CPU typedefs; div_unit SHALL import cpu_pkg.
REQ-028 A single sub-module, div_step, SHALL implement one combinational shift-subtract step (remainder, dividend bit in -> new remainder, quotient bit out).

Verification
REQ-029 WIDTH=16, unsigned: 100/7 -> Done at cycle 19, Quotient=14, Remainder=2, DivZero=0.
REQ-030 1234/0 -> Done at cycle 2, Quotient=16'hFFFF, Remainder=1234, DivZero=1.
REQ-031 DIV_SIGNED_EN: -7/2 -> Quotient=-3, Remainder=-1; -32768/-1 -> Quotient=-32768, Remainder=0.
REQ-032 Start=1 held for 30 cycles with operands changing after cycle 0 -> exactly one Done per accepted Start, each result computed from the operands captured at its own accept cycle.
REQ-033 Rst pulsed at cycle 8 of an operation -> all outputs 0 immediately, no Done; a new Start afterwards completes correctly.
REQ-034 WIDTH=32 unsigned: 32'hFFFFFFFF/1 -> Quotient=32'hFFFFFFFF, Remainder=0, latency 35 cycles.
